bcd2bin_entry: RTL and testbench
================================

// Module: bcd2bin_entry
// PURPOSE
//  Decimal-entry decoder for the IN path; the inverse of the Bin2BCD display encoder.
//  Takes a sign flag plus DIGITS packed BCD digits from the entry switches and converts them,
//  one digit per clock, into a WIDTH-bit two's-complement word.
//  The result is driven to the RDM input mux in place of raw binary switches.
//  start/busy/done handshake with the control unit; out-of-range or non-BCD input is flagged.
// PARAMETERS
//  DIGITS  5   number of BCD digits in bcd_in (most significant digit first)
//  WIDTH   16  result width, two's complement
// PORTS
//  clk       in   1           system clock (100 Hz domain, same as control unit)
//  rst_n     in   1           asynchronous reset, active-low
//  start     in   1           request conversion; sampled on rising edge of clk
//  sign_in   in   1           1 = negative entry
//  bcd_in    in   4*DIGITS    packed BCD; [4*DIGITS-1 -: 4] is most significant digit
//  busy      out  1           conversion in progress
//  done      out  1           one-cycle pulse; value/invalid/overflow valid from this cycle
//  value     out  WIDTH       converted two's-complement result; held until next done
//  invalid   out  1           a digit > 9 was present; sticky until next accepted start
//  overflow  out  1           magnitude out of range for sign; sticky until next accepted start
// BEHAVIOUR
//  Interface: one clock, clk. Reset is asynchronous and active-low (rst_n).
//  - Reset: state=IDLE; busy=0, done=0, value=0, invalid=0, overflow=0.
//    Internal acc, sign and digit index are also cleared.
//  - Reset mid-conversion aborts to IDLE with no done pulse.
//  - FSM states and transitions:
//    - IDLE: on start=1, latch bcd_in and sign_in, acc=0, idx=DIGITS-1.
//      Clear invalid/overflow, busy=1, go to CONV.
//    - CONV: per clock, acc <= acc*10 + digit[idx], idx decrements.
//      If digit[idx] > 9, set internal bad flag and add 0 for that digit.
//      After the idx=0 digit, go to FIN.
//    - FIN: compute flags and value, pulse done=1 for one cycle, busy=0, return to IDLE.
//      - If bad: invalid=1, value=0.
//      - Else, if sign=0 and acc > 2^(WIDTH-1)-1, or sign=1 and acc > 2^(WIDTH-1):
//        overflow=1, value=0.
//      - Otherwise value = sign ? -acc : acc, truncated to WIDTH bits.
//  - Accumulator width: ceil(log2(10^DIGITS)) bits (17 for defaults).
//    Unsigned arithmetic, no internal wrap.
//  - Latency: start sampled at edge k -> CONV at edges k+1..k+DIGITS -> FIN at edge
//    k+DIGITS+1. done is high in the cycle after edge k+DIGITS+1 (6 cycles with defaults).
//  - start while busy=1: ignored; no queuing, the latched operands are unchanged.
//  - start held high continuously: a new conversion begins on the edge after done (back-to-back).
//  - -0 (sign=1, all digits 0): value=0, overflow=0.
//  - bcd_in/sign_in changes after the start edge do not affect the running conversion.
//  - invalid takes priority over overflow; both are never set together.
// TESTING
//  - sign=0, bcd=0x12345, start pulse -> done 6 cycles later; value=0x3039, flags 0; busy high 5 cycles.
//  - sign=1, bcd=0x32768 -> value=0x8000, overflow=0.
//  - sign=0, bcd=0x32768 -> overflow=1, value=0.
//  - sign=1, bcd=0x00000 -> value=0x0000, overflow=0.
//  - sign=0, bcd=0x1A000 -> invalid=1, overflow=0, value=0.
//    Next start with 0x00042 -> invalid clears on accept, value=0x002A.
//  - start re-pulsed at cycle 2 of a conversion with different bcd_in -> ignored;
//    the original result appears at the original done time.
//  - rst_n low at cycle 3 of a conversion -> all outputs 0 immediately, no done;
//    a fresh start after release converts normally.

Source files
------------

// File: rtl/bcd2bin_entry.sv
// rtl/bcd2bin_entry.sv - serial packed-BCD to two's-complement entry decoder
// Converts one digit per clock, MSD first; flags non-BCD digits and out-of-range magnitudes.

module bcd2bin_entry #(
  parameter int DIGITS = 5,
  parameter int WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sign_in,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      value,
  output logic                  invalid,
  output logic                  overflow
);

  localparam int ACC_W = $clog2(10 ** DIGITS);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CMP_W = ((ACC_W > WIDTH) ? ACC_W : WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  // Negative range reaches one further than positive: 2^(WIDTH-1) vs 2^(WIDTH-1)-1.
  localparam logic [CMP_W-1:0] LIM_NEG  = {{(CMP_W-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CMP_W-1:0] LIM_POS  = LIM_NEG - CMP_W'(1);

  logic [1:0]            r_state;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  r_sign;
  logic [ACC_W-1:0]      r_acc;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_bad;
  logic                  r_busy;
  logic                  r_done;
  logic [WIDTH-1:0]      r_value;
  logic                  r_invalid;
  logic                  r_overflow;

  logic [3:0]            w_digit;
  logic                  w_digit_ok;
  logic [ACC_W-1:0]      w_acc_next;
  logic [CMP_W-1:0]      w_acc_ext;
  logic                  w_ovf;
  logic [WIDTH-1:0]      w_mag;
  logic [WIDTH-1:0]      w_signed;

  // Latched operand shifts left each step, so the current digit is always the top nibble.
  assign w_digit    = r_bcd[4*DIGITS-1 -: 4];
  assign w_digit_ok = (w_digit <= 4'd9);
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + ACC_W'(w_digit_ok ? w_digit : 4'd0);

  assign w_acc_ext  = CMP_W'(r_acc);
  assign w_ovf      = r_sign ? (w_acc_ext > LIM_NEG) : (w_acc_ext > LIM_POS);
  assign w_mag      = w_acc_ext[WIDTH-1:0];
  assign w_signed   = r_sign ? (~w_mag + WIDTH'(1)) : w_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bcd      <= '0;
      r_sign     <= 1'b0;
      r_acc      <= '0;
      r_idx      <= '0;
      r_bad      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_value    <= '0;
      r_invalid  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bcd      <= bcd_in;
            r_sign     <= sign_in;
            r_acc      <= '0;
            r_idx      <= LAST_IDX;
            r_bad      <= 1'b0;
            r_invalid  <= 1'b0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_CONV;
          end
        end
        S_CONV: begin
          r_acc <= w_acc_next;
          r_bcd <= r_bcd << 4;
          if (!w_digit_ok) begin
            r_bad <= 1'b1;
          end
          if (r_idx == '0) begin
            r_busy  <= 1'b0;
            r_state <= S_FIN;
          end else begin
            r_idx <= r_idx - IDX_W'(1);
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
          if (r_bad) begin
            r_invalid <= 1'b1;
            r_value   <= '0;
          end else if (w_ovf) begin
            r_overflow <= 1'b1;
            r_value    <= '0;
          end else begin
            r_value <= w_signed;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign value    = r_value;
  assign invalid  = r_invalid;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_bcd2bin_entry.sv
// tb/tb_bcd2bin_entry.sv - directed scoreboard bench for bcd2bin_entry
// Expected results come from an integer decimal model and are popped when done pulses.

module tb_bcd2bin_entry;

  typedef struct packed {
    logic        inv;
    logic        ovf;
    logic [15:0] val;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sign_in;
  logic [19:0] bcd_in;
  logic        busy;
  logic        done;
  logic [15:0] value;
  logic        invalid;
  logic        overflow;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  bcd2bin_entry #(.DIGITS(5), .WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sign_in  (sign_in),
    .bcd_in   (bcd_in),
    .busy     (busy),
    .done     (done),
    .value    (value),
    .invalid  (invalid),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic s, input logic [19:0] b);
    exp_t       e;
    int         acc;
    bit         bad;
    logic [3:0] d;
    acc = 0;
    bad = 0;
    for (int i = 4; i >= 0; i--) begin
      d = b[4*i +: 4];
      if (d > 4'd9) bad = 1;
      else          acc = acc * 10 + int'(d);
    end
    e = '0;
    if (bad)                                          e.inv = 1'b1;
    else if ((!s && acc > 32767) || (s && acc > 32768)) e.ovf = 1'b1;
    else                                              e.val = s ? 16'(-acc) : 16'(acc);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        check("value",    32'(value),    32'(e.val));
        check("invalid",  32'(invalid),  32'(e.inv));
        check("overflow", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  task automatic run_conv(input logic s, input logic [19:0] b, input int repulse);
    int n;
    int nbusy;
    sign_in = s;
    bcd_in  = b;
    start   = 1'b1;
    sb.push_back(model(s, b));
    step();
    check("accept_busy",     32'(busy),     32'd1);
    check("accept_inv_clr",  32'(invalid),  32'd0);
    check("accept_ovf_clr",  32'(overflow), 32'd0);
    nbusy   = int'(busy);
    start   = 1'b0;
    bcd_in  = 20'h99999;
    sign_in = ~s;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      if (n + 1 == repulse) begin
        start  = 1'b1;
        bcd_in = 20'h00777;
      end else begin
        start = 1'b0;
      end
      step();
      n++;
      nbusy += int'(busy);
    end
    start = 1'b0;
    check("latency",     32'(n),     32'd6);
    check("busy_cycles", 32'(nbusy), 32'd5);
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    start   = 1'b0;
    sign_in = 1'b0;
    bcd_in  = '0;
    repeat (3) step();
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_value",    32'(value),    32'd0);
    check("rst_invalid",  32'(invalid),  32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    step();

    run_conv(1'b0, 20'h12345, 0);
    run_conv(1'b1, 20'h32768, 0);
    run_conv(1'b0, 20'h32768, 0);
    run_conv(1'b1, 20'h00000, 0);
    run_conv(1'b0, 20'h1A000, 0);
    run_conv(1'b0, 20'h00042, 0);
    run_conv(1'b0, 20'h32767, 0);
    run_conv(1'b1, 20'h32769, 0);
    run_conv(1'b1, 20'h99999, 0);
    run_conv(1'b0, 20'h9A999, 0);
    run_conv(1'b1, 20'h0000F, 0);
    run_conv(1'b1, 20'h01234, 0);
    run_conv(1'b0, 20'h12345, 2);

    // Back-to-back: start held high across the first done.
    sign_in = 1'b0;
    bcd_in  = 20'h00100;
    start   = 1'b1;
    sb.push_back(model(1'b0, 20'h00100));
    step();
    bcd_in = 20'h00200;
    sb.push_back(model(1'b0, 20'h00200));
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("b2b_first", 32'(n), 32'd6);
    n = 0;
    do begin
      step();
      n++;
    end while (done !== 1'b1 && n < 20);
    check("b2b_gap", 32'(n), 32'd7);
    start = 1'b0;
    repeat (10) step();
    check("b2b_drained", 32'(sb.size()), 32'd0);

    // Reset in the middle of a conversion.
    sign_in = 1'b0;
    bcd_in  = 20'h00555;
    start   = 1'b1;
    sb.push_back(model(1'b0, 20'h00555));
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_busy",     32'(busy),     32'd0);
    check("midrst_done",     32'(done),     32'd0);
    check("midrst_value",    32'(value),    32'd0);
    check("midrst_invalid",  32'(invalid),  32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    sb.delete();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (8) step();
    run_conv(1'b0, 20'h00042, 0);
    repeat (3) step();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
